// File: rtl/axi_pkg.sv
// Shared AXI read-side definitions: bus widths, burst and response encodings, read FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axi_pkg;

    // Slave-side bus widths (ID = {master tag, master ID}).
    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_ADDR_BITS = 32;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Only full 32-bit beats are served.
    localparam logic [2:0] SIZE_WORD   = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } rd_state_e;

    // WRAP and the reserved encoding are both answered with SLVERR.
    function automatic logic burst_supported(input logic [1:0] burst);
        return (burst == BURST_FIXED) || (burst == BURST_INCR);
    endfunction

endpackage

// File: rtl/axi_read_responder_if.sv
// AR/R channel bundle between one interconnect slave port and a read responder.
// Latency: n/a (wires only).
// Backpressure: n/a; slave modport = responder side, master modport = interconnect side.
interface axi_read_responder_if;
    import axi_pkg::*;

    logic [AXI_IDS_BITS-1:0]  ARID_S;
    logic [AXI_ADDR_BITS-1:0] ARADDR_S;
    logic [3:0]               ARLEN_S;
    logic [2:0]               ARSIZE_S;
    logic [1:0]               ARBURST_S;
    logic                     ARVALID_S;
    logic                     ARREADY_S;

    logic [AXI_IDS_BITS-1:0]  RID_S;
    logic [AXI_DATA_BITS-1:0] RDATA_S;
    logic [1:0]               RRESP_S;
    logic                     RLAST_S;
    logic                     RVALID_S;
    logic                     RREADY_S;

    modport slave (
        input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
        output ARREADY_S,
        output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        input  RREADY_S
    );

    modport master (
        output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
        input  ARREADY_S,
        input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        output RREADY_S
    );

endinterface

// File: rtl/axi_burst_addr.sv
// Burst address stepper: next byte address and SRAM word address for the current beat.
// Latency: combinational.
// Backpressure: advances only when the caller strobes advance (an accepted non-final beat).
// Ports: addr/burst = latched request state; advance = step strobe;
//        next_addr = address to latch; mem_a = SRAM word index of next_addr.
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int MEM_AW = 14
) (
    input  logic [31:0]       addr,
    input  logic [1:0]        burst,
    input  logic              advance,
    output logic [31:0]       next_addr,
    output logic [MEM_AW-1:0] mem_a
);

    // FIXED (and error bursts, which never touch memory) keep the address.
    always_comb begin
        next_addr = addr;
        if (advance && (burst == BURST_INCR)) begin
            next_addr = addr + 32'd4;
        end
    end

    // Upper address bits are simply dropped, so an INCR burst past the top
    // word wraps to word 0.
    assign mem_a = next_addr[MEM_AW+1:2];

endmodule

// File: rtl/axi_read_responder.sv
// Slave AXI read engine: one AR at a time, reads a sync SRAM, returns an R burst with RLAST.
// Latency: AR accepted in T -> mem_ce T+1 -> first RVALID T+2; one beat per cycle when RREADY high.
// Backpressure: ARREADY low while a burst is in flight; R beat held stable until RREADY, next read issued on handshake.
// Ports: clk/rst (sync, active high); s = AR/R slave channel; mem_ce/mem_a/mem_do = SRAM read port.
module axi_read_responder
    import axi_pkg::*;
#(
    parameter int          MEM_AW   = 14,
    parameter logic [31:0] ERR_DATA = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    axi_read_responder_if.slave s,
    output logic              mem_ce,
    output logic [MEM_AW-1:0] mem_a,
    input  logic [31:0]       mem_do
);

    rd_state_e               state_q, state_d;
    logic [AXI_IDS_BITS-1:0] id_q, id_d;
    logic [31:0]             addr_q, addr_d;
    logic [3:0]              len_q, len_d;
    logic [3:0]              beat_cnt_q, beat_cnt_d;
    logic [1:0]              burst_q, burst_d;
    logic                    err_q, err_d;

    logic        advance;
    logic [31:0] next_addr;
    logic        last;
    logic        ar_err;

    // Error is decided once at AR time; later address stepping never raises it.
    assign ar_err = (s.ARSIZE_S != SIZE_WORD)
                  | !burst_supported(s.ARBURST_S)
                  | (s.ARADDR_S[31:MEM_AW+2] != '0);

    assign last = (beat_cnt_q == len_q);

    axi_burst_addr #(
        .MEM_AW (MEM_AW)
    ) u_burst_addr (
        .addr      (addr_q),
        .burst     (burst_q),
        .advance   (advance),
        .next_addr (next_addr),
        .mem_a     (mem_a)
    );

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        burst_d    = burst_q;
        err_d      = err_q;

        advance     = 1'b0;
        mem_ce      = 1'b0;
        s.ARREADY_S = 1'b0;
        s.RVALID_S  = 1'b0;
        s.RID_S     = '0;
        s.RDATA_S   = '0;
        s.RRESP_S   = RESP_OKAY;
        s.RLAST_S   = 1'b0;

        case (state_q)
            IDLE: begin
                s.ARREADY_S = 1'b1;
                if (s.ARVALID_S) begin
                    id_d       = s.ARID_S;
                    addr_d     = s.ARADDR_S;
                    len_d      = s.ARLEN_S;
                    burst_d    = s.ARBURST_S;
                    err_d      = ar_err;
                    beat_cnt_d = '0;
                    state_d    = FETCH;
                end
            end

            FETCH: begin
                // mem_a already shows addr_q since advance is low here.
                mem_ce  = !err_q;
                state_d = RESP;
            end

            RESP: begin
                s.RVALID_S = 1'b1;
                s.RID_S    = id_q;
                s.RLAST_S  = last;
                s.RDATA_S  = err_q ? ERR_DATA : mem_do;
                s.RRESP_S  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (s.RREADY_S) begin
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        // Fetch the next word in the handshake cycle so it
                        // lands on mem_do exactly when the next beat shows.
                        // While stalled, mem_do must not change, hence no
                        // strobe outside a handshake.
                        advance    = 1'b1;
                        beat_cnt_d = beat_cnt_q + 4'd1;
                        addr_d     = next_addr;
                        mem_ce     = !err_q;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            burst_q    <= BURST_FIXED;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            burst_q    <= burst_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_read_responder.sv
// Testbench for axi_read_responder: directed scenarios plus randomized bursts vs a burst-level model.
// Latency: n/a.
// Backpressure: RREADY driven always-high, 0,0,1 per beat, or random.
module tb_axi_read_responder;
    import axi_pkg::*;

    localparam int          MEM_AW   = 14;
    localparam int          NWORDS   = 1 << MEM_AW;
    localparam logic [31:0] ERR_DATA = 32'hBAD0_0BAD;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_read_responder_if bus();
    logic              mem_ce;
    logic [MEM_AW-1:0] mem_a;
    logic [31:0]       mem_do;

    axi_read_responder #(
        .MEM_AW   (MEM_AW),
        .ERR_DATA (ERR_DATA)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s      (bus),
        .mem_ce (mem_ce),
        .mem_a  (mem_a),
        .mem_do (mem_do)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous SRAM model, fed from values sampled mid-cycle.
    logic [31:0]       mem [NWORDS];
    logic              ce_s = 1'b0;
    logic [MEM_AW-1:0] a_s  = '0;
    int                ce_cyc_q[$];
    int                ce_addr_q[$];
    always @(negedge clk) begin
        #2;
        ce_s = mem_ce;
        a_s  = mem_a;
        if (mem_ce === 1'b1) begin
            ce_cyc_q.push_back(cyc);
            ce_addr_q.push_back(int'(mem_a));
        end
    end
    always @(posedge clk) if (ce_s) mem_do <= mem[a_s];

    // Observed beats of the last burst.
    logic [31:0] obs_data[$];
    logic [7:0]  obs_id[$];
    logic [1:0]  obs_resp[$];
    logic        obs_last[$];
    int          obs_cyc[$];
    int          t_ar, t_back, stab_viol;
    logic        timeout;

    // ---------------- reference model ----------------
    function automatic logic mdl_err(input logic [31:0] addr, input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'b010) || (burst > 2'b01) || ((addr >> (MEM_AW + 2)) != 0);
    endfunction

    function automatic int mdl_word(input logic [31:0] addr, input logic [1:0] burst, input int k);
        int unsigned w;
        w = (addr >> 2) + ((burst == 2'b01) ? k : 0);
        return int'(w % NWORDS);
    endfunction

    function automatic logic [31:0] mdl_data(input logic [31:0] addr, input logic [2:0] size,
                                             input logic [1:0] burst, input int k);
        if (mdl_err(addr, size, burst)) return ERR_DATA;
        return mem[mdl_word(addr, burst, k)];
    endfunction

    // ---------------- driver / collector ----------------
    // mode 0: RREADY always high; 1: 0,0,1 per beat; 2: random.
    task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int mode);
        int   wait_n, guard;
        logic stalled, done;
        logic [31:0] pd; logic [7:0] pid; logic [1:0] pr; logic pl;
        obs_data.delete(); obs_id.delete(); obs_resp.delete(); obs_last.delete(); obs_cyc.delete();
        ce_cyc_q.delete(); ce_addr_q.delete();
        timeout = 1'b0; stab_viol = 0;
        @(negedge clk);
        bus.ARID_S = id; bus.ARADDR_S = addr; bus.ARLEN_S = len;
        bus.ARSIZE_S = size; bus.ARBURST_S = burst; bus.ARVALID_S = 1'b1;
        bus.RREADY_S = (mode == 0);
        #1;
        guard = 0;
        while (bus.ARREADY_S !== 1'b1 && guard < 50) begin @(negedge clk); #1; guard++; end
        t_ar = cyc;
        wait_n = 0; stalled = 1'b0; done = 1'b0; guard = 0;
        pd = '0; pid = '0; pr = '0; pl = 1'b0;
        while (!done && guard < 300) begin
            @(negedge clk);
            bus.ARVALID_S = 1'b0;
            case (mode)
                0:       bus.RREADY_S = 1'b1;
                1:       bus.RREADY_S = (wait_n >= 2);
                default: bus.RREADY_S = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (stalled && (bus.RVALID_S !== 1'b1 || bus.RDATA_S !== pd || bus.RID_S !== pid ||
                            bus.RRESP_S !== pr || bus.RLAST_S !== pl)) stab_viol++;
            if (bus.RVALID_S === 1'b1) begin
                if (bus.RREADY_S) begin
                    obs_data.push_back(bus.RDATA_S); obs_id.push_back(bus.RID_S);
                    obs_resp.push_back(bus.RRESP_S); obs_last.push_back(bus.RLAST_S);
                    obs_cyc.push_back(cyc);
                    stalled = 1'b0; wait_n = 0;
                    if (bus.RLAST_S === 1'b1) done = 1'b1;
                end else begin
                    stalled = 1'b1; wait_n++;
                    pd = bus.RDATA_S; pid = bus.RID_S; pr = bus.RRESP_S; pl = bus.RLAST_S;
                end
            end
            guard++;
        end
        timeout = !done;
        guard = 0;
        do begin @(negedge clk); bus.RREADY_S = 1'b0; #1; guard++; end
        while (bus.ARREADY_S !== 1'b1 && guard < 50);
        t_back = cyc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++; if (bus.ARREADY_S !== 1'b1) begin n_err++; $display("FAIL reset_arready got %b want 1", bus.ARREADY_S); end
        n_vec++; if (bus.RVALID_S !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got %b want 0", bus.RVALID_S); end
        n_vec++; if (bus.RLAST_S !== 1'b0) begin n_err++; $display("FAIL reset_rlast got %b want 0", bus.RLAST_S); end
        n_vec++; if (bus.RRESP_S !== 2'b00) begin n_err++; $display("FAIL reset_rresp got %b want 00", bus.RRESP_S); end
        n_vec++; if (bus.RID_S !== 8'h00) begin n_err++; $display("FAIL reset_rid got %h want 00", bus.RID_S); end
        n_vec++; if (bus.RDATA_S !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", bus.RDATA_S); end
        n_vec++; if (mem_ce !== 1'b0) begin n_err++; $display("FAIL reset_mem_ce got %b want 0", mem_ce); end
        n_vec++; if (mem_a !== '0) begin n_err++; $display("FAIL reset_mem_a got %h want 0", mem_a); end
    endtask

    task automatic test_single_beat();
        mem[4] = 32'hDEAD_BEEF;
        run_burst(8'h21, 32'h0000_0010, 4'd0, 3'b010, BURST_INCR, 0);
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL single_timeout got %b want 0", timeout); end
        n_vec++; if (ce_cyc_q.size() != 1) begin n_err++; $display("FAIL single_ce_cnt got %0d want 1", ce_cyc_q.size()); end
        else begin
            n_vec++; if (ce_addr_q[0] != 4) begin n_err++; $display("FAIL single_mem_a got %0d want 4", ce_addr_q[0]); end
            n_vec++; if (ce_cyc_q[0] != t_ar + 1) begin n_err++; $display("FAIL single_ce_time got %0d want %0d", ce_cyc_q[0], t_ar + 1); end
        end
        n_vec++; if (obs_data.size() != 1) begin n_err++; $display("FAIL single_beats got %0d want 1", obs_data.size()); end
        else begin
            n_vec++; if (obs_data[0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_rdata got %h want deadbeef", obs_data[0]); end
            n_vec++; if (obs_id[0] !== 8'h21) begin n_err++; $display("FAIL single_rid got %h want 21", obs_id[0]); end
            n_vec++; if (obs_last[0] !== 1'b1) begin n_err++; $display("FAIL single_rlast got %b want 1", obs_last[0]); end
            n_vec++; if (obs_resp[0] !== 2'b00) begin n_err++; $display("FAIL single_rresp got %b want 00", obs_resp[0]); end
            n_vec++; if (obs_cyc[0] != t_ar + 2) begin n_err++; $display("FAIL single_rvalid_time got %0d want %0d", obs_cyc[0], t_ar + 2); end
        end
        n_vec++; if (t_back != t_ar + 3) begin n_err++; $display("FAIL single_arready_back got %0d want %0d", t_back, t_ar + 3); end
    endtask

    task automatic test_incr();
        run_burst(8'h5A, 32'h0000_0100, 4'd3, 3'b010, BURST_INCR, 0);
        n_vec++; if (ce_cyc_q.size() != 4) begin n_err++; $display("FAIL incr_ce_cnt got %0d want 4", ce_cyc_q.size()); end
        else for (int k = 0; k < 4; k++) begin
            n_vec++; if (ce_addr_q[k] != 64 + k) begin n_err++; $display("FAIL incr_mem_a[%0d] got %0d want %0d", k, ce_addr_q[k], 64 + k); end
            n_vec++; if (ce_cyc_q[k] != t_ar + 1 + k) begin n_err++; $display("FAIL incr_ce_time[%0d] got %0d want %0d", k, ce_cyc_q[k], t_ar + 1 + k); end
        end
        n_vec++; if (obs_data.size() != 4) begin n_err++; $display("FAIL incr_beats got %0d want 4", obs_data.size()); end
        else for (int k = 0; k < 4; k++) begin
            n_vec++; if (obs_data[k] !== mem[64 + k]) begin n_err++; $display("FAIL incr_rdata[%0d] got %h want %h", k, obs_data[k], mem[64 + k]); end
            n_vec++; if (obs_cyc[k] != t_ar + 2 + k) begin n_err++; $display("FAIL incr_beat_time[%0d] got %0d want %0d", k, obs_cyc[k], t_ar + 2 + k); end
            n_vec++; if (obs_last[k] !== (k == 3)) begin n_err++; $display("FAIL incr_rlast[%0d] got %b want %b", k, obs_last[k], k == 3); end
        end
        n_vec++; if (t_back != t_ar + 6) begin n_err++; $display("FAIL incr_arready_back got %0d want %0d", t_back, t_ar + 6); end
    endtask

    task automatic test_backpressure();
        run_burst(8'hC3, 32'h0000_0100, 4'd3, 3'b010, BURST_INCR, 1);
        n_vec++; if (stab_viol != 0) begin n_err++; $display("FAIL bp_stable got %0d want 0", stab_viol); end
        n_vec++; if (obs_data.size() != 4) begin n_err++; $display("FAIL bp_beats got %0d want 4", obs_data.size()); end
        else for (int k = 0; k < 4; k++) begin
            n_vec++; if (obs_data[k] !== mem[64 + k]) begin n_err++; $display("FAIL bp_rdata[%0d] got %h want %h", k, obs_data[k], mem[64 + k]); end
            n_vec++; if (obs_id[k] !== 8'hC3) begin n_err++; $display("FAIL bp_rid[%0d] got %h want c3", k, obs_id[k]); end
            n_vec++; if (obs_last[k] !== (k == 3)) begin n_err++; $display("FAIL bp_rlast[%0d] got %b want %b", k, obs_last[k], k == 3); end
        end
        n_vec++; if (ce_cyc_q.size() != 4) begin n_err++; $display("FAIL bp_ce_cnt got %0d want 4", ce_cyc_q.size()); end
        else if (obs_cyc.size() == 4) for (int k = 1; k < 4; k++) begin
            n_vec++; if (ce_cyc_q[k] != obs_cyc[k - 1]) begin n_err++; $display("FAIL bp_ce_time[%0d] got %0d want %0d", k, ce_cyc_q[k], obs_cyc[k - 1]); end
        end
    endtask

    task automatic test_fixed();
        run_burst(8'h07, 32'h0000_0040, 4'd2, 3'b010, BURST_FIXED, 0);
        n_vec++; if (ce_addr_q.size() != 3) begin n_err++; $display("FAIL fixed_ce_cnt got %0d want 3", ce_addr_q.size()); end
        else for (int k = 0; k < 3; k++) begin
            n_vec++; if (ce_addr_q[k] != 16) begin n_err++; $display("FAIL fixed_mem_a[%0d] got %0d want 16", k, ce_addr_q[k]); end
        end
        n_vec++; if (obs_data.size() != 3) begin n_err++; $display("FAIL fixed_beats got %0d want 3", obs_data.size()); end
        else for (int k = 0; k < 3; k++) begin
            n_vec++; if (obs_data[k] !== mem[16]) begin n_err++; $display("FAIL fixed_rdata[%0d] got %h want %h", k, obs_data[k], mem[16]); end
            n_vec++; if (obs_last[k] !== (k == 2)) begin n_err++; $display("FAIL fixed_rlast[%0d] got %b want %b", k, obs_last[k], k == 2); end
        end
    endtask

    task automatic test_wrap();
        // Top two words then wrap to words 0 and 1, all OKAY.
        run_burst(8'h99, 32'h0000_FFF8, 4'd3, 3'b010, BURST_INCR, 0);
        n_vec++; if (obs_data.size() != 4) begin n_err++; $display("FAIL wrap_beats got %0d want 4", obs_data.size()); end
        else for (int k = 0; k < 4; k++) begin
            n_vec++; if (obs_data[k] !== mem[(NWORDS - 2 + k) % NWORDS]) begin n_err++; $display("FAIL wrap_rdata[%0d] got %h want %h", k, obs_data[k], mem[(NWORDS - 2 + k) % NWORDS]); end
            n_vec++; if (obs_resp[k] !== 2'b00) begin n_err++; $display("FAIL wrap_rresp[%0d] got %b want 00", k, obs_resp[k]); end
        end
    endtask

    task automatic test_errors();
        logic [31:0] ea [3];
        logic [2:0]  es [3];
        logic [1:0]  eb [3];
        logic [3:0]  el [3];
        ea[0] = 32'h0000_0020; es[0] = 3'b010; eb[0] = 2'b10; el[0] = 4'd1;
        ea[1] = 32'h0001_0000; es[1] = 3'b010; eb[1] = 2'b01; el[1] = 4'd0;
        ea[2] = 32'h0000_0080; es[2] = 3'b011; eb[2] = 2'b01; el[2] = 4'd2;
        for (int e = 0; e < 3; e++) begin
            run_burst(8'h3C, ea[e], el[e], es[e], eb[e], 0);
            n_vec++; if (ce_cyc_q.size() != 0) begin n_err++; $display("FAIL err%0d_mem_ce got %0d want 0", e, ce_cyc_q.size()); end
            n_vec++; if (obs_data.size() != int'(el[e]) + 1) begin n_err++; $display("FAIL err%0d_beats got %0d want %0d", e, obs_data.size(), int'(el[e]) + 1); end
            else for (int k = 0; k <= int'(el[e]); k++) begin
                n_vec++; if (obs_resp[k] !== 2'b10) begin n_err++; $display("FAIL err%0d_rresp[%0d] got %b want 10", e, k, obs_resp[k]); end
                n_vec++; if (obs_data[k] !== ERR_DATA) begin n_err++; $display("FAIL err%0d_rdata[%0d] got %h want %h", e, k, obs_data[k], ERR_DATA); end
                n_vec++; if (obs_last[k] !== (k == int'(el[e]))) begin n_err++; $display("FAIL err%0d_rlast[%0d] got %b", e, k, obs_last[k]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int hs, guard;
        @(negedge clk);
        bus.ARID_S = 8'h44; bus.ARADDR_S = 32'h0000_0100; bus.ARLEN_S = 4'd3;
        bus.ARSIZE_S = 3'b010; bus.ARBURST_S = BURST_INCR; bus.ARVALID_S = 1'b1; bus.RREADY_S = 1'b1;
        hs = 0; guard = 0;
        while (hs < 2 && guard < 50) begin
            @(negedge clk); bus.ARVALID_S = 1'b0; #1;
            if (bus.RVALID_S === 1'b1 && bus.RREADY_S) hs++;
            guard++;
        end
        n_vec++; if (hs != 2) begin n_err++; $display("FAIL rstmid_pre_beats got %0d want 2", hs); end
        @(negedge clk); rst = 1'b1; bus.RREADY_S = 1'b0;
        @(negedge clk); rst = 1'b0; #1;
        n_vec++; if (bus.RVALID_S !== 1'b0) begin n_err++; $display("FAIL rstmid_rvalid got %b want 0", bus.RVALID_S); end
        n_vec++; if (bus.ARREADY_S !== 1'b1) begin n_err++; $display("FAIL rstmid_arready got %b want 1", bus.ARREADY_S); end
        // AR presented together with reset must be dropped.
        @(negedge clk); rst = 1'b1; bus.ARVALID_S = 1'b1; ce_cyc_q.delete();
        @(negedge clk); rst = 1'b0; bus.ARVALID_S = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        n_vec++; if (ce_cyc_q.size() != 0) begin n_err++; $display("FAIL rst_ar_ignored_ce got %0d want 0", ce_cyc_q.size()); end
        n_vec++; if (bus.ARREADY_S !== 1'b1) begin n_err++; $display("FAIL rst_ar_ignored_arready got %b want 1", bus.ARREADY_S); end
        run_burst(8'h45, 32'h0000_0200, 4'd1, 3'b010, BURST_INCR, 0);
        n_vec++; if (obs_data.size() != 2) begin n_err++; $display("FAIL rstmid_after_beats got %0d want 2", obs_data.size()); end
        else for (int k = 0; k < 2; k++) begin
            n_vec++; if (obs_data[k] !== mem[128 + k]) begin n_err++; $display("FAIL rstmid_after_rdata[%0d] got %h want %h", k, obs_data[k], mem[128 + k]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] id; logic [31:0] addr; logic [3:0] len; logic [2:0] size; logic [1:0] burst;
        int r, nb; logic err;
        for (int t = 0; t < 30; t++) begin
            id  = 8'($urandom); len = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 9);
            burst = (r < 5) ? 2'b01 : (r < 8) ? 2'b00 : 2'($urandom_range(2, 3));
            size  = ($urandom_range(0, 9) == 0) ? 3'b001 : 3'b010;
            r = $urandom_range(0, 9);
            addr = (r == 0) ? (32'($urandom) | 32'h0004_0000) : 32'($urandom_range(0, (4 * NWORDS) - 1));
            run_burst(id, addr, len, size, burst, 2);
            err = mdl_err(addr, size, burst);
            nb  = int'(len) + 1;
            n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL rnd%0d_timeout", t); end
            n_vec++; if (stab_viol != 0) begin n_err++; $display("FAIL rnd%0d_stable got %0d want 0", t, stab_viol); end
            n_vec++; if (ce_cyc_q.size() != (err ? 0 : nb)) begin n_err++; $display("FAIL rnd%0d_ce_cnt got %0d want %0d", t, ce_cyc_q.size(), err ? 0 : nb); end
            else for (int k = 0; k < ce_addr_q.size(); k++) begin
                n_vec++; if (ce_addr_q[k] != mdl_word(addr, burst, k)) begin n_err++; $display("FAIL rnd%0d_mem_a[%0d] got %0d want %0d", t, k, ce_addr_q[k], mdl_word(addr, burst, k)); end
            end
            n_vec++; if (obs_data.size() != nb) begin n_err++; $display("FAIL rnd%0d_beats got %0d want %0d", t, obs_data.size(), nb); end
            else for (int k = 0; k < nb; k++) begin
                n_vec++; if (obs_data[k] !== mdl_data(addr, size, burst, k)) begin n_err++; $display("FAIL rnd%0d_rdata[%0d] got %h want %h", t, k, obs_data[k], mdl_data(addr, size, burst, k)); end
                n_vec++; if (obs_id[k] !== id) begin n_err++; $display("FAIL rnd%0d_rid[%0d] got %h want %h", t, k, obs_id[k], id); end
                n_vec++; if (obs_resp[k] !== (err ? 2'b10 : 2'b00)) begin n_err++; $display("FAIL rnd%0d_rresp[%0d] got %b want %b", t, k, obs_resp[k], err ? 2'b10 : 2'b00); end
                n_vec++; if (obs_last[k] !== (k == nb - 1)) begin n_err++; $display("FAIL rnd%0d_rlast[%0d] got %b", t, k, obs_last[k]); end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
        rst = 1'b1;
        bus.ARID_S = '0; bus.ARADDR_S = '0; bus.ARLEN_S = '0; bus.ARSIZE_S = 3'b010;
        bus.ARBURST_S = 2'b01; bus.ARVALID_S = 1'b0; bus.RREADY_S = 1'b0;
        test_reset();
        test_single_beat();
        test_incr();
        test_backpressure();
        test_fixed();
        test_wrap();
        test_errors();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
